// File: rtl/sprite_fetch_sched_pkg.sv
// Shared types and constants for the sprite fetch scheduler.
// Fetch states are ordered so the fetch steps form a contiguous range.
package sprite_fetch_sched_pkg;

  typedef enum logic [3:0] {
    F_IDLE,
    F_WAIT,
    F_OAM0,
    F_OAM1,
    F_LO0,
    F_LO1,
    F_HI0,
    F_HI1,
    F_DONE,
    F_CLR
  } fetch_state_e;

  typedef enum logic {
    S_IDLE,
    S_EVAL
  } scan_state_e;

  localparam int unsigned EVAL_CYCLES_DEFAULT = 80;
  localparam logic        VRAM_SPR_BANK       = 1'b0;

  // States in which a pending fetch can still be abandoned.
  function automatic logic fetch_abortable(fetch_state_e s);
    return (s >= F_WAIT) && (s <= F_HI1);
  endfunction

endpackage

// File: rtl/sprite_fetch_sched_oam_scan_timer.sv
// OAM scan window sequencer: eval-reset pulse at line start, then EVAL_CYCLES ce of oam_eval.
module oam_scan_timer
  import sprite_fetch_sched_pkg::*;
#(
  parameter int unsigned EVAL_CYCLES = EVAL_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_ce,
  input  logic i_lcd_on,
  input  logic i_line_start,
  input  logic i_vblank,
  output logic o_oam_eval_reset,
  output logic o_oam_eval,
  output logic o_scan_idle
);

  localparam logic [6:0] EvalLast = 7'(EVAL_CYCLES);

  scan_state_e r_state, w_state_d;
  logic [6:0]  r_cnt, w_cnt_d;
  logic        r_eval_reset, w_eval_reset_d;
  logic        r_eval, w_eval_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_eval_reset <= 1'b0;
      r_eval       <= 1'b0;
    end else if (i_ce) begin
      if (!i_lcd_on) begin
        r_state      <= S_IDLE;
        r_cnt        <= '0;
        r_eval_reset <= 1'b0;
        r_eval       <= 1'b0;
      end else begin
        r_state      <= w_state_d;
        r_cnt        <= w_cnt_d;
        r_eval_reset <= w_eval_reset_d;
        r_eval       <= w_eval_d;
      end
    end
  end

  // A new line always restarts the window, even mid-scan.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    if (i_line_start) begin
      w_state_d = i_vblank ? S_IDLE : S_EVAL;
      w_cnt_d   = '0;
    end else if (r_state == S_EVAL) begin
      if (r_cnt == EvalLast) begin
        w_state_d = S_IDLE;
        w_cnt_d   = '0;
      end else begin
        w_cnt_d = r_cnt + 7'd1;
      end
    end
  end

  always_comb begin
    w_eval_reset_d = i_line_start;
    w_eval_d       = !i_line_start && (r_state == S_EVAL) && (r_cnt != EvalLast);
  end

  assign o_oam_eval_reset = r_eval_reset;
  assign o_oam_eval       = r_eval;
  assign o_scan_idle      = (r_state == S_IDLE);

endmodule

// File: rtl/sprite_fetch_sched.sv
// Per-line sprite scheduler: OAM scan window plus the mode-3 sprite pattern fetch,
// stalling the background fetcher and reading both pattern bytes from VRAM.
module sprite_fetch_sched
  import sprite_fetch_sched_pkg::*;
#(
  parameter int unsigned EVAL_CYCLES = EVAL_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        lcd_on,
  input  logic        line_start,
  input  logic        vblank,
  input  logic        mode3,
  input  logic        bg_fetch_ready,
  input  logic        sprite_fetch,
  input  logic [10:0] sprite_addr,
  input  logic [7:0]  vram_data,
  output logic        oam_eval_reset,
  output logic        oam_eval,
  output logic        oam_fetch,
  output logic        sprite_fetch_done,
  output logic        bg_stall,
  output logic        vram_rd,
  output logic [12:0] vram_addr,
  output logic [7:0]  spr_lo,
  output logic [7:0]  spr_hi,
  output logic        spr_valid
);

  fetch_state_e r_state, w_state_d;
  logic         w_scan_idle;
  logic         w_oam_eval;
  logic         w_start;
  logic         w_abort;
  logic         r_addr_hi;
  logic [7:0]   r_lo, r_hi;

  oam_scan_timer #(
    .EVAL_CYCLES(EVAL_CYCLES)
  ) u_scan (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_ce            (ce),
    .i_lcd_on        (lcd_on),
    .i_line_start    (line_start),
    .i_vblank        (vblank),
    .o_oam_eval_reset(oam_eval_reset),
    .o_oam_eval      (w_oam_eval),
    .o_scan_idle     (w_scan_idle)
  );

  assign oam_eval  = w_oam_eval;
  assign oam_fetch = lcd_on & ~reset & mode3 & ~w_oam_eval;
  assign w_start   = sprite_fetch & oam_fetch & w_scan_idle;
  assign w_abort   = line_start | ~mode3 | ~sprite_fetch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= F_IDLE;
    end else if (ce) begin
      r_state <= lcd_on ? w_state_d : F_IDLE;
    end
  end

  // F_CLR chains straight into F_WAIT when another same-x sprite is pending.
  always_comb begin
    w_state_d = r_state;
    if (fetch_abortable(r_state) && w_abort) begin
      w_state_d = F_IDLE;
    end else begin
      unique case (r_state)
        F_IDLE:  w_state_d = w_start ? F_WAIT : F_IDLE;
        F_WAIT:  w_state_d = bg_fetch_ready ? F_OAM0 : F_WAIT;
        F_OAM0, F_OAM1, F_LO0, F_LO1, F_HI0, F_HI1:
                 w_state_d = fetch_state_e'(r_state + 4'd1);
        F_DONE:  w_state_d = F_CLR;
        F_CLR:   w_state_d = w_start ? F_WAIT : F_IDLE;
        default: w_state_d = F_IDLE;
      endcase
    end
  end

  always_comb begin
    bg_stall          = (r_state != F_IDLE) && (r_state != F_CLR);
    vram_rd           = (r_state == F_LO0) || (r_state == F_HI0);
    sprite_fetch_done = (r_state == F_DONE);
    spr_valid         = (r_state == F_DONE);
  end

  // Read data arrives the ce after the strobe, i.e. while in F_LO1 / F_HI1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_hi <= 1'b0;
      r_lo      <= '0;
      r_hi      <= '0;
    end else if (ce) begin
      if (!lcd_on) begin
        r_addr_hi <= 1'b0;
        r_lo      <= '0;
        r_hi      <= '0;
      end else begin
        if (w_state_d == F_LO0) r_addr_hi <= 1'b0;
        if (w_state_d == F_HI0) r_addr_hi <= 1'b1;
        if (r_state == F_LO1 && w_state_d == F_HI0) r_lo <= vram_data;
        if (r_state == F_HI1 && w_state_d == F_DONE) r_hi <= vram_data;
      end
    end
  end

  assign vram_addr = {VRAM_SPR_BANK, sprite_addr, r_addr_hi};
  assign spr_lo    = r_lo;
  assign spr_hi    = r_hi;

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Bench for sprite_fetch_sched: directed table and corner sequences, then random
// stimulus against a phase-count reference model.
module tb_sprite_fetch_sched;

  localparam int EVAL = 80;

  logic        clk = 1'b0;
  logic        reset, ce, lcd_on, line_start, vblank, mode3, bg_fetch_ready, sprite_fetch;
  logic [10:0] sprite_addr;
  logic [7:0]  vram_data;
  logic        oam_eval_reset, oam_eval, oam_fetch, sprite_fetch_done, bg_stall, vram_rd;
  logic        spr_valid;
  logic [12:0] vram_addr;
  logic [7:0]  spr_lo, spr_hi;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sprite_fetch_sched #(.EVAL_CYCLES(EVAL)) dut (
    .clk              (clk),
    .reset            (reset),
    .ce               (ce),
    .lcd_on           (lcd_on),
    .line_start       (line_start),
    .vblank           (vblank),
    .mode3            (mode3),
    .bg_fetch_ready   (bg_fetch_ready),
    .sprite_fetch     (sprite_fetch),
    .sprite_addr      (sprite_addr),
    .vram_data        (vram_data),
    .oam_eval_reset   (oam_eval_reset),
    .oam_eval         (oam_eval),
    .oam_fetch        (oam_fetch),
    .sprite_fetch_done(sprite_fetch_done),
    .bg_stall         (bg_stall),
    .vram_rd          (vram_rd),
    .vram_addr        (vram_addr),
    .spr_lo           (spr_lo),
    .spr_hi           (spr_hi),
    .spr_valid        (spr_valid)
  );

  typedef struct {
    logic        sf;
    logic        rdy;
    logic [7:0]  data;
    logic        stall;
    logic        rd;
    logic        done;
    logic [12:0] addr;
    logic [7:0]  lo;
    logic [7:0]  hi;
  } vec_t;

  vec_t vecs[10];

  // Reference model: fetch phase 0 idle, 1 waiting, 2..8 = seven steps to done, 9 clear.
  int          m_ph;
  bit          m_scan_on;
  int          m_left;
  bit          m_er, m_ev, m_ahi;
  bit [7:0]    m_lo, m_hi;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ph = 0; m_scan_on = 0; m_left = 0; m_er = 0; m_ev = 0; m_ahi = 0; m_lo = 0; m_hi = 0;
  endtask

  task automatic model_edge();
    bit fetch_ok, start, abort;
    int nph;
    if (!ce) return;
    if (!lcd_on) begin
      model_reset();
      return;
    end
    fetch_ok = mode3 && !m_ev;
    start    = sprite_fetch && fetch_ok && !m_scan_on;
    abort    = line_start || !mode3 || !sprite_fetch;
    if (m_ph == 0 || m_ph == 9)  nph = start ? 1 : 0;
    else if (m_ph == 8)          nph = 9;
    else if (abort)              nph = 0;
    else if (m_ph == 1)          nph = bg_fetch_ready ? 2 : 1;
    else                         nph = m_ph + 1;
    if (m_ph == 5 && nph == 6) m_lo = vram_data;
    if (m_ph == 7 && nph == 8) m_hi = vram_data;
    if (nph == 4) m_ahi = 0;
    if (nph == 6) m_ahi = 1;
    m_ph = nph;
    if (line_start) begin
      m_er = 1; m_ev = 0; m_scan_on = !vblank; m_left = EVAL;
    end else begin
      m_er = 0;
      if (m_scan_on) begin
        if (m_left > 0) begin
          m_ev = 1; m_left--;
        end else begin
          m_ev = 0; m_scan_on = 0;
        end
      end
    end
  endtask

  initial begin
    int cnt, t1, t2, cyc;
    bit saw_done, bad_fetch;
    logic [63:0] exp_v, act_v;

    reset = 1; ce = 1; lcd_on = 1; line_start = 0; vblank = 0; mode3 = 0;
    bg_fetch_ready = 0; sprite_fetch = 0; sprite_addr = 11'h123; vram_data = 8'h00;

    vecs[0] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 13'h0246, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 13'h0246, 8'h00, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 13'h0246, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 13'h0246, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 13'h0246, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 13'h0247, 8'hA5, 8'h00};
    vecs[6] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 13'h0247, 8'hA5, 8'h00};
    vecs[7] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 13'h0247, 8'hA5, 8'h3C};
    vecs[8] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 13'h0247, 8'hA5, 8'h3C};
    vecs[9] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 13'h0247, 8'hA5, 8'h3C};

    // Reset state
    step(); step();
    check("reset_outs", 64'({oam_eval_reset, oam_eval, oam_fetch, sprite_fetch_done, bg_stall,
                             vram_rd, spr_valid, spr_lo, spr_hi}), 64'd0);
    reset = 0;
    step();
    check("idle_after_reset", 64'({oam_eval_reset, oam_eval, bg_stall}), 64'd0);

    // OAM scan window
    line_start = 1;
    step();
    check("eval_reset_pulse", 64'({oam_eval_reset, oam_eval}), 64'b10);
    line_start = 0; mode3 = 1;
    step();
    check("eval_rise", 64'({oam_eval_reset, oam_eval}), 64'b01);
    cnt = 1; bad_fetch = 0;
    for (int i = 0; i < 200; i++) begin
      if (oam_fetch || oam_eval_reset) bad_fetch = 1;
      step();
      if (oam_eval) cnt++;
      else break;
    end
    check("eval_len", 64'(cnt), 64'(EVAL));
    check("no_fetch_in_eval", 64'(bad_fetch), 64'd0);
    check("fetch_after_eval", 64'(oam_fetch), 64'd1);

    // Basic fetch table
    for (int i = 0; i < 10; i++) begin
      sprite_fetch = vecs[i].sf; bg_fetch_ready = vecs[i].rdy; vram_data = vecs[i].data;
      step();
      check($sformatf("vec%0d", i),
            64'({bg_stall, vram_rd, sprite_fetch_done, spr_valid, vram_addr, spr_lo, spr_hi}),
            64'({vecs[i].stall, vecs[i].rd, vecs[i].done, vecs[i].done, vecs[i].addr,
                 vecs[i].lo, vecs[i].hi}));
    end

    // Vblank line: pulse only
    line_start = 1; vblank = 1;
    step();
    check("vblank_pulse", 64'({oam_eval_reset, oam_eval}), 64'b10);
    line_start = 0;
    step();
    check("vblank_no_eval", 64'({oam_eval_reset, oam_eval}), 64'b00);
    vblank = 0;

    // Background fetcher not ready for 5 ce
    sprite_fetch = 1; bg_fetch_ready = 0;
    step();
    check("wait_stall", 64'({bg_stall, vram_rd}), 64'b10);
    bad_fetch = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!bg_stall || vram_rd) bad_fetch = 1;
    end
    check("held_wait", 64'(bad_fetch), 64'd0);
    bg_fetch_ready = 1;
    step(); step(); step();
    check("rd_after_ready", 64'({bg_stall, vram_rd, vram_addr}), 64'({2'b11, 13'h0246}));
    sprite_fetch = 0;
    step();
    check("abort_sf_drop", 64'({bg_stall, vram_rd, sprite_fetch_done}), 64'd0);
    step();
    check("abort_no_done", 64'({sprite_fetch_done, spr_valid}), 64'd0);

    // Two same-x sprites back to back
    sprite_fetch = 1; bg_fetch_ready = 1; t1 = -1; t2 = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sprite_fetch_done) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
    end
    check("same_x_spacing", 64'(t2 - t1), 64'd9);
    sprite_fetch = 0;
    step(); step(); step();

    // Line start during F_LO1
    sprite_fetch = 1;
    step(); step(); step(); step();
    check("lo0_rd", 64'(vram_rd), 64'd1);
    step();
    line_start = 1;
    step();
    check("ls_abort", 64'({bg_stall, oam_eval_reset, sprite_fetch_done}), 64'b010);
    line_start = 0;
    saw_done = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sprite_fetch_done || spr_valid || bg_stall) saw_done = 1;
    end
    check("ls_no_done", 64'(saw_done), 64'd0);
    check("ls_eval_on", 64'(oam_eval), 64'd1);

    // LCD off mid-eval
    lcd_on = 0;
    step();
    check("lcd_off", 64'({oam_eval_reset, oam_eval, oam_fetch, sprite_fetch_done, bg_stall,
                          vram_rd, spr_valid, spr_lo, spr_hi}), 64'd0);
    lcd_on = 1; sprite_fetch = 0;
    step(); step();
    check("lcd_on_idle", 64'(oam_eval), 64'd0);

    // Async reset mid-fetch
    sprite_fetch = 1;
    step(); step(); step();
    check("pre_rst_stall", 64'(bg_stall), 64'd1);
    #2 reset = 1;
    #1;
    check("async_rst", 64'({oam_eval_reset, oam_eval, oam_fetch, sprite_fetch_done, bg_stall,
                            vram_rd, spr_valid, spr_lo, spr_hi}), 64'd0);
    step();
    reset = 0; sprite_fetch = 0;
    step();

    // Randomized run against the model
    reset = 1;
    step();
    model_reset();
    reset = 0; lcd_on = 1; mode3 = 1; vblank = 0; sprite_fetch = 0; line_start = 0;
    for (cyc = 0; cyc < 4000; cyc++) begin
      ce = ($urandom_range(7) != 0);
      if (lcd_on) begin
        if ($urandom_range(299) == 0) lcd_on = 0;
      end else if ($urandom_range(7) == 0) begin
        lcd_on = 1;
      end
      line_start     = ($urandom_range(249) == 0);
      if ($urandom_range(199) == 0) vblank = ~vblank;
      if ($urandom_range(39) == 0) mode3 = ~mode3;
      if ($urandom_range(11) == 0) sprite_fetch = ~sprite_fetch;
      bg_fetch_ready = ($urandom_range(3) != 0);
      sprite_addr    = 11'($urandom);
      vram_data      = 8'($urandom);
      @(posedge clk);
      model_edge();
      #1;
      exp_v = 64'({m_er, m_ev, lcd_on && mode3 && !m_ev, m_ph == 8, m_ph >= 1 && m_ph <= 8,
                   m_ph == 4 || m_ph == 6, m_ph == 8,
                   {1'b0, sprite_addr, m_ahi}, m_lo, m_hi});
      act_v = 64'({oam_eval_reset, oam_eval, oam_fetch, sprite_fetch_done, bg_stall, vram_rd,
                   spr_valid, vram_addr, spr_lo, spr_hi});
      check($sformatf("rand%0d", cyc), act_v, exp_v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
